// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between the writeback requesters and the register bank.
// The master side drives requests and the bank stall. The slave side (the
// arbiter) returns the one-hot grant and the registered write command.
interface regfile_write_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*ADDR_W-1:0]   req_addr;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic                     stall;
    logic [NREQ-1:0]          req_ready;
    logic [(1<<ADDR_W)-1:0]   wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [1:0]               grant_id;
    logic                     busy;

    modport master (
        output req_valid, req_addr, req_data, stall,
        input  req_ready, wr_en, wr_addr, wr_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, stall,
        output req_ready, wr_en, wr_addr, wr_data, grant_id, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Four requesters compete each cycle. The winner's address is decoded into a
// registered one-hot write enable that drives the register bank directly.
// Writes to register 0 are swallowed: the grant is consumed, but no enable fires.
// Optional macro WB_BYPASS_EN adds a read-side forwarding compare against
// the write that is landing in the bank this cycle.
module regfile_write_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    regfile_write_arbiter_if.slave  bus
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]       byp_raddr,
    output logic                    byp_hit,
    output logic [DATA_W-1:0]       byp_data
`endif
);

    localparam int NREG = 1 << ADDR_W;

    logic [1:0]         ptr;
    logic [1:0]         winner;
    logic [1:0]         idx;
    logic               found;
    logic [NREQ-1:0]    grant;
    logic               transfer;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;
    logic [NREG-1:0]    en_next;

    logic [NREG-1:0]    wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic [1:0]         grant_id_q;
    logic               busy_q;

    // Scan requesters starting at the pointer and take the first valid one.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Decode the winner into a one-hot grant, suppressed by stall or reset.
    always_comb begin
        grant = '0;
        if (found && !bus.stall && reset_n) begin
            case (winner)
                2'd0:    grant = 4'b0001;
                2'd1:    grant = 4'b0010;
                2'd2:    grant = 4'b0100;
                default: grant = 4'b1000;
            endcase
        end
    end

    assign transfer      = |grant;
    assign bus.req_ready = grant;

    // Steer the winner's address and data toward the output registers.
    always_comb begin
        win_addr = bus.req_addr[ADDR_W-1:0];
        win_data = bus.req_data[DATA_W-1:0];
        case (winner)
            2'd0: begin
                win_addr = bus.req_addr[0*ADDR_W +: ADDR_W];
                win_data = bus.req_data[0*DATA_W +: DATA_W];
            end
            2'd1: begin
                win_addr = bus.req_addr[1*ADDR_W +: ADDR_W];
                win_data = bus.req_data[1*DATA_W +: DATA_W];
            end
            2'd2: begin
                win_addr = bus.req_addr[2*ADDR_W +: ADDR_W];
                win_data = bus.req_data[2*DATA_W +: DATA_W];
            end
            default: begin
                win_addr = bus.req_addr[3*ADDR_W +: ADDR_W];
                win_data = bus.req_data[3*DATA_W +: DATA_W];
            end
        endcase
    end

    // Decode the winning address to a one-hot enable, leaving register 0 unwritable.
    always_comb begin
        en_next = '0;
        if (win_addr != '0) begin
            en_next[win_addr] = 1'b1;
        end
    end

    // Register the write command and advance the pointer past each winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= 2'd0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
        end else if (transfer) begin
            ptr        <= winner + 2'd1;
            wr_en_q    <= en_next;
            wr_addr_q  <= win_addr;
            wr_data_q  <= win_data;
            grant_id_q <= winner;
            busy_q     <= |en_next;
        end else begin
            wr_en_q    <= '0;
            busy_q     <= 1'b0;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;

`ifdef WB_BYPASS_EN
    assign byp_hit  = busy_q && (byp_raddr == wr_addr_q) && (byp_raddr != '0);
    assign byp_data = byp_hit ? wr_data_q : '0;
`endif

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32-entry register file between four requesters (e.g. ALU writeback, load unit, link-register write, debug port).
- Arbitration is round-robin. The winning 5-bit destination address is decoded 5-to-32 into a registered one-hot write-enable bus that drives the register bank directly.
- Grant selection is decoded 2-to-4 into a one-hot grant vector.
- Sits between the writeback stage and the register bank.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 to match the 2-to-4 grant decode.
- ADDR_W, 5, register address width; fixed at 5 to match the 5-to-32 enable decode.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  4  per-requester write request
- req_addr  input  20  packed destination addresses; requester i at bits [5i+4:5i]
- req_data  input  128  packed write data; requester i at bits [32i+31:32i]
- stall  input  1  register bank busy; blocks all grants this cycle
- req_ready  output  4  one-hot grant; transfer for requester i when req_valid[i] and req_ready[i] are both high
- wr_en  output  32  registered one-hot register write enable
- wr_addr  output  5  registered winning address
- wr_data  output  32  registered winning data
- grant_id  output  2  registered index of last winner
- busy  output  1  registered; high while wr_en is nonzero

Behaviour:
- Reset (asynchronous, reset_n low):
  - wr_en=0, wr_addr=0, wr_data=0, grant_id=0, busy=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while reset_n is low.
- Arbitration (combinational, same cycle):
  - Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
  - The first requester with req_valid set wins. Its 2-bit index is decoded to one-hot req_ready.
  - No valid requests, or stall=1: req_ready=0.
  - req_ready never depends on req_addr or req_data.
- Pointer update (clocked):
  - On a transfer, ptr <= winner+1 mod 4. Index 3 wraps to 0.
  - No transfer: ptr holds.
- Output stage (clocked, latency exactly 1 cycle from grant to write):
  - On a transfer: wr_addr <= winner addr, wr_data <= winner data, grant_id <= winner index.
  - wr_en <= 5-to-32 one-hot decode of winner addr, except addr 0, which gives wr_en=0 (register $zero is write-protected; the grant is still consumed).
  - busy <= |next wr_en.
  - No transfer: wr_en <= 0, busy <= 0, wr_addr/wr_data/grant_id hold.
- wr_en is always either zero or exactly one-hot. It is never asserted for two cycles from a single transfer.
- The register bank always accepts a write, so there is no back-pressure from the output stage. Throughput is one write per cycle.
- Simultaneous requests to the same address from different requesters:
  - Serialized in round-robin order.
  - The later grant overwrites the earlier one in the bank.
- A requester that keeps req_valid high gets at most one grant per 4 cycles when all four requesters are active. No requester starves.
- stall asserted mid-stream:
  - The grant in that cycle is blocked.
  - A write already registered still appears on wr_en in the stall cycle.
- reset_n asserted mid-operation: all outputs clear immediately, including any pending wr_en.

Optional Feature:
- Macro: WB_BYPASS_EN.
- With the macro defined, adds three ports:
  - byp_raddr  input  5
  - byp_hit  output  1
  - byp_data  output  32
- byp_hit = busy and (byp_raddr == wr_addr) and (byp_raddr != 0). This is combinational from the registered outputs.
- byp_data = wr_data when byp_hit is high, else 0.
- This lets the read stage forward the write landing this cycle.
- Without the macro, the ports do not exist and no compare logic is built.

Test Plan:
- Reset then idle: reset_n low mid-cycle -> all outputs 0 asynchronously; with req_valid=0 afterwards, wr_en stays 0 and ptr stays 0.
- Single request: req_valid=0001, addr0=5'd9, data0=32'hDEADBEEF -> req_ready=0001 the same cycle; next cycle wr_en=32'h00000200, wr_data=DEADBEEF, grant_id=0, busy=1.
- All four requesting for 8 cycles with distinct addresses -> grants in order 0,1,2,3,0,1,2,3; wr_en sequence matches each address one-hot, one per cycle.
- Zero register: requester 2 writes addr 0 -> req_ready=0100; next cycle wr_en=0, busy=0; ptr advances to 3.
- Stall: requests 0011 with stall=1 for 2 cycles -> req_ready=0000 and wr_en=0 in the following cycles; after stall drops, requester 0 is granted first, then 1.
- WB_BYPASS_EN: write addr 17 with data 32'h12345678, byp_raddr=17 in the write cycle -> byp_hit=1, byp_data=12345678; byp_raddr=16 -> byp_hit=0.
